// File: rtl/game_pkg.sv
// Shared definitions for the shooter game.
// Contents:
//   fire_state_t      - firing FSM states (IDLE, FIRE, FLIGHT, COOLDOWN)
//   V_TICK            - scanline where the once-per-frame tick fires
//   H_VISIBLE/V_VISIBLE - visible screen size
//   sat_sub()         - unsigned subtract that clamps at zero
package game_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    FLIGHT   = 2'd2,
    COOLDOWN = 2'd3
  } fire_state_t;

  localparam logic [9:0] V_TICK    = 10'd480;
  localparam int         H_VISIBLE = 640;
  localparam int         V_VISIBLE = 480;

  // Keeps a bullet spawned near the top edge on screen instead of wrapping.
  function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? 10'd0 : (a - b);
  endfunction

endpackage

// File: rtl/bullet_fire_ctrl_if.sv
// Link between the fire controller and the bullet sprite engine.
// Signals:
//   shoot         - one-clk launch strobe (controller -> engine)
//   xloc_start    - launch x, held stable (controller -> engine)
//   yloc_start    - launch y, held stable (controller -> engine)
//   move          - bullet step request (controller -> engine)
//   bullet_broken - 1 = no bullet alive (engine -> controller)
// Modports: master = fire controller, slave = bullet engine.
interface bullet_fire_ctrl_if;
  logic       shoot;
  logic [9:0] xloc_start;
  logic [9:0] yloc_start;
  logic       move;
  logic       bullet_broken;

  modport master (
    output shoot,
    output xloc_start,
    output yloc_start,
    output move,
    input  bullet_broken
  );

  modport slave (
    input  shoot,
    input  xloc_start,
    input  yloc_start,
    input  move,
    output bullet_broken
  );
endinterface

// File: rtl/bullet_fire_ctrl_btn_debounce.sv
// Fire button conditioner: 2-FF synchroniser, stability counter and
// one-clk press event.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   btn      - raw asynchronous button
//   level    - debounced button level
//   press    - one-clk pulse on each accepted 0->1 change of level
// Parameter DEB_CYCLES: consecutive clks the synchronised input must hold a
// new value before level follows it (0 behaves like 1).
module btn_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [19:0] DEB_LAST = (DEB_CYCLES == 20'd0) ? 20'd0 : DEB_CYCLES - 20'd1;

  logic        sync1_reg;
  logic        sync2_reg;
  logic        level_reg;
  logic        press_reg;
  logic [19:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= 20'd0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        // cnt_reg counts earlier clks already spent at the new value, so the
        // update lands on the DEB_CYCLES-th consecutive one.
        if (cnt_reg >= DEB_LAST) begin
          level_reg <= sync2_reg;
          press_reg <= sync2_reg;
          cnt_reg   <= 20'd0;
        end else begin
          cnt_reg <= cnt_reg + 20'd1;
        end
      end else begin
        cnt_reg <= 20'd0;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/bullet_fire_ctrl.sv
// Bullet fire controller: turns the debounced fire button into single
// bullet launches, keeps one bullet in flight with a frame-based cooldown,
// and produces the per-frame move step for the bullet engine.
// Ports:
//   clk, rst      - 100 MHz clock, asynchronous active-high reset
//   pixpulse      - pixel enable (one clk in four)
//   hcount/vcount - current pixel position
//   fire_btn      - raw fire button
//   ship_x/ship_y - ship centre
//   bus           - engine link (shoot, xloc_start, yloc_start, move, bullet_broken)
//   ready         - a press now would fire
//   shots_fired   - launch count, wraps at 255
// Optional macro AUTOFIRE_EN: a held button keeps firing, one shot per
// flight + cooldown cycle. Without it only a fresh press fires.
module bullet_fire_ctrl
  import game_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES      = 20'd500000,
  parameter logic [3:0]  COOLDOWN_FRAMES = 4'd8,
  parameter logic [2:0]  MOVE_DIV        = 3'd1,
  parameter logic [9:0]  Y_OFFSET        = 10'd6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pixpulse,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  input  logic                      fire_btn,
  input  logic [9:0]                ship_x,
  input  logic [9:0]                ship_y,
  bullet_fire_ctrl_if.master        bus,
  output logic                      ready,
  output logic [7:0]                shots_fired
);

  localparam logic [2:0] MOVE_LAST = (MOVE_DIV == 3'd0) ? 3'd0 : MOVE_DIV - 3'd1;

  logic        btn_level;
  logic        btn_press;
  logic        fire_req;
  logic        frame_tick;

  fire_state_t state_reg, state_next;
  logic [3:0]  cd_reg, cd_next;
  logic        guard_reg;
  logic        shoot_reg;
  logic [9:0]  xloc_reg;
  logic [9:0]  yloc_reg;
  logic [7:0]  shots_reg;
  logic [2:0]  div_reg;
  logic        move_reg;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (fire_btn),
    .level (btn_level),
    .press (btn_press)
  );

`ifdef AUTOFIRE_EN
  assign fire_req = btn_press | btn_level;
`else
  assign fire_req = btn_press;
`endif

  assign frame_tick = pixpulse & (hcount == 10'd0) & (vcount == V_TICK);

  always_comb begin
    state_next = state_reg;
    cd_next    = cd_reg;
    case (state_reg)
      IDLE: begin
        // Presses while a bullet is alive are simply dropped.
        if (fire_req && bus.bullet_broken) begin
          state_next = FIRE;
        end
      end
      FIRE: begin
        state_next = FLIGHT;
      end
      FLIGHT: begin
        // guard_reg masks the first flight clk, while the engine may still
        // report the old broken status.
        if (!guard_reg && bus.bullet_broken) begin
          if (COOLDOWN_FRAMES == 4'd0) begin
            state_next = IDLE;
          end else begin
            state_next = COOLDOWN;
            cd_next    = COOLDOWN_FRAMES;
          end
        end
      end
      COOLDOWN: begin
        if (cd_reg == 4'd0) begin
          state_next = IDLE;
        end else if (frame_tick) begin
          cd_next = cd_reg - 4'd1;
          if (cd_reg == 4'd1) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cd_reg    <= 4'd0;
      guard_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cd_reg    <= cd_next;
      guard_reg <= (state_reg == FIRE);
    end
  end

  // Launch outputs are registered on entry to FIRE so shoot and the launch
  // coordinates appear together during the FIRE clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shoot_reg <= 1'b0;
      xloc_reg  <= 10'd0;
      yloc_reg  <= 10'd0;
      shots_reg <= 8'd0;
    end else begin
      shoot_reg <= 1'b0;
      if (state_next == FIRE && state_reg != FIRE) begin
        shoot_reg <= 1'b1;
        xloc_reg  <= ship_x;
        yloc_reg  <= sat_sub(ship_y, Y_OFFSET);
        shots_reg <= shots_reg + 8'd1;
      end
    end
  end

  // move rises on the wrapping frame tick and falls on the following pixel
  // enable, so the engine (which acts on pixpulse) sees exactly one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg  <= 3'd0;
      move_reg <= 1'b0;
    end else begin
      if (frame_tick) begin
        if (div_reg >= MOVE_LAST) begin
          div_reg <= 3'd0;
        end else begin
          div_reg <= div_reg + 3'd1;
        end
      end
      if (frame_tick && div_reg >= MOVE_LAST) begin
        move_reg <= 1'b1;
      end else if (pixpulse) begin
        move_reg <= 1'b0;
      end
    end
  end

  assign bus.shoot      = shoot_reg;
  assign bus.xloc_start = xloc_reg;
  assign bus.yloc_start = yloc_reg;
  assign bus.move       = move_reg;
  assign ready          = (state_reg == IDLE) & bus.bullet_broken;
  assign shots_fired    = shots_reg;

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// Directed bench for bullet_fire_ctrl. A scoreboard queue holds the expected
// launch (x, y, count) for each press that should fire; a monitor pops and
// compares on every shoot strobe and also emulates the engine clearing
// bullet_broken on launch. A second instance covers COOLDOWN_FRAMES = 0.
module tb_bullet_fire_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pixpulse = 1'b0;
  logic [9:0] hcount = 10'd1;
  logic [9:0] vcount = 10'd0;
  logic       fire_btn = 1'b0;
  logic       fire_btn2 = 1'b0;
  logic [9:0] ship_x = 10'd320;
  logic [9:0] ship_y = 10'd480;
  logic       ready, ready2;
  logic [7:0] shots, shots2;

  bullet_fire_ctrl_if bus ();
  bullet_fire_ctrl_if bus2 ();

  bullet_fire_ctrl #(
    .DEB_CYCLES      (20'd4),
    .COOLDOWN_FRAMES (4'd2),
    .MOVE_DIV        (3'd3),
    .Y_OFFSET        (10'd6)
  ) dut (
    .clk (clk), .rst (rst), .pixpulse (pixpulse), .hcount (hcount), .vcount (vcount),
    .fire_btn (fire_btn), .ship_x (ship_x), .ship_y (ship_y), .bus (bus),
    .ready (ready), .shots_fired (shots)
  );

  bullet_fire_ctrl #(
    .DEB_CYCLES      (20'd4),
    .COOLDOWN_FRAMES (4'd0),
    .MOVE_DIV        (3'd1),
    .Y_OFFSET        (10'd6)
  ) dut2 (
    .clk (clk), .rst (rst), .pixpulse (pixpulse), .hcount (hcount), .vcount (vcount),
    .fire_btn (fire_btn2), .ship_x (ship_x), .ship_y (ship_y), .bus (bus2),
    .ready (ready2), .shots_fired (shots2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] n;
  } shot_t;

  shot_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    pix_cnt = 0;
  int    move_rises = 0;
  int    move_pix = 0;
  logic  move_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pixel enable: one clk in four.
  initial begin
    forever begin
      @(negedge clk);
      pix_cnt = (pix_cnt + 1) % 4;
      pixpulse = (pix_cnt == 0);
    end
  end

  // Shoot scoreboard, engine emulation and move statistics.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.shoot) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_shoot observed queue=0 expected queue>0");
        end
        if (sb.size() > 0) begin
          shot_t e;
          e = sb.pop_front();
          chk("sb_xloc", bus.xloc_start, e.x);
          chk("sb_yloc", bus.yloc_start, e.y);
          chk("sb_count", shots, e.n);
          $display("shot x=%0d y=%0d count=%0d", bus.xloc_start, bus.yloc_start, shots);
        end
        bus.bullet_broken = 1'b0;
      end
      if (bus2.shoot) begin
        bus2.bullet_broken = 1'b0;
      end
      if (bus.move && !move_prev) move_rises++;
      if (bus.move && pixpulse) move_pix++;
      move_prev = bus.move;
    end
  end

  task automatic press();
    fire_btn = 1'b1;
    repeat (6) @(negedge clk);
    fire_btn = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic press2();
    fire_btn2 = 1'b1;
    repeat (6) @(negedge clk);
    fire_btn2 = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  // Holds hcount/vcount at the tick position for four clks: exactly one pixpulse.
  task automatic frame_tick();
    hcount = 10'd0;
    vcount = V_TICK;
    repeat (4) @(negedge clk);
    hcount = 10'd1;
    vcount = 10'd0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.bullet_broken  = 1'b1;
    bus2.bullet_broken = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_shoot", bus.shoot, 0);
    chk("rst_move", bus.move, 0);
    chk("rst_xloc", bus.xloc_start, 0);
    chk("rst_yloc", bus.yloc_start, 0);
    chk("rst_shots", shots, 0);
    chk("rst_ready", ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // 3-clk glitch must not fire.
    fire_btn = 1'b1;
    repeat (3) @(negedge clk);
    fire_btn = 1'b0;
    repeat (14) @(negedge clk);
    chk("glitch_shots", shots, 0);

    // Proper press fires once.
    sb.push_back('{x: 10'd320, y: 10'd474, n: 8'd1});
    press();
    chk("shot1_seen", sb.size(), 0);
    chk("shot1_count", shots, 1);
    chk("shot1_xloc", bus.xloc_start, 320);
    chk("shot1_yloc", bus.yloc_start, 474);
    chk("flight_ready", ready, 0);

    // Press while the bullet is alive is dropped.
    press();
    chk("alive_press_shots", shots, 1);
    chk("alive_press_ready", ready, 0);

    // Bullet dies: cooldown of two frames.
    bus.bullet_broken = 1'b1;
    repeat (2) @(negedge clk);
    chk("cooldown_ready", ready, 0);
    frame_tick();
    press();
    chk("tick1_press_shots", shots, 1);
    chk("tick1_ready", ready, 0);
    frame_tick();
    chk("tick2_ready", ready, 1);

    // Spawn y saturates at zero.
    ship_x = 10'd100;
    ship_y = 10'd3;
    sb.push_back('{x: 10'd100, y: 10'd0, n: 8'd2});
    press();
    chk("shot2_seen", sb.size(), 0);
    chk("shot2_yloc", bus.yloc_start, 0);
    chk("shot2_xloc", bus.xloc_start, 100);
    chk("shot2_count", shots, 2);

    // MOVE_DIV = 3: nine frames give three single-pixpulse moves.
    move_rises = 0;
    move_pix = 0;
    repeat (9) frame_tick();
    repeat (8) @(negedge clk);
    chk("move_rises", move_rises, 3);
    chk("move_pixpulses", move_pix, 3);
    $display("move rises=%0d pixpulses=%0d", move_rises, move_pix);

    // COOLDOWN_FRAMES = 0 instance: ready the clk after the bullet dies.
    press2();
    chk("cd0_shot_count", shots2, 1);
    chk("cd0_flight_ready", ready2, 0);
    bus2.bullet_broken = 1'b1;
    #1;
    chk("cd0_same_clk_ready", ready2, 0);
    @(negedge clk);
    chk("cd0_next_clk_ready", ready2, 1);
    press2();
    chk("cd0_second_shot", shots2, 2);

    // Asynchronous reset in flight.
    chk("pre_rst_ready", ready, 0);
    @(negedge clk);
    #3;
    rst = 1'b1;
    bus.bullet_broken = 1'b1;
    #1;
    chk("async_rst_shots", shots, 0);
    chk("async_rst_shoot", bus.shoot, 0);
    chk("async_rst_move", bus.move, 0);
    chk("async_rst_xloc", bus.xloc_start, 0);
    chk("async_rst_ready", ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb.push_back('{x: 10'd100, y: 10'd0, n: 8'd1});
    press();
    chk("post_rst_count", shots, 1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_fire_ctrl.md
Name: bullet_fire_ctrl

Overview:
- Upstream feeder for the bullet sprite engine in the VGA shooter game.
- Debounces the player fire button and enforces one bullet in flight plus a frame-based cooldown.
- Issues the single-cycle `shoot` strobe with the launch coordinates (`xloc_start`/`yloc_start`), taken from the ship position.
- Generates the per-frame `move` step that advances the bullet.

Parameters:
- DEB_CYCLES, 20'd500000: consecutive stable clk cycles needed to accept a button level (5 ms at 100 MHz).
- COOLDOWN_FRAMES, 4'd8: frames after bullet death before the next shot is allowed; 0 = none.
- MOVE_DIV, 3'd1: frame ticks per `move` step (1 = every frame).
- Y_OFFSET, 10'd6: pixels above ship_y where the bullet spawns.

Ports:
- clk, input, 1: 100 MHz system clock.
- rst, input, 1: asynchronous active-high reset.
- pixpulse, input, 1: 25 MHz pixel enable, one clk in four.
- hcount, input, 10: current pixel x.
- vcount, input, 10: current pixel y.
- fire_btn, input, 1: raw, asynchronous fire button.
- ship_x, input, 10: ship centre x.
- ship_y, input, 10: ship centre y.
- bullet_broken, input, 1: bullet engine status; 1 = no bullet alive.
- shoot, output reg, 1: one-clk launch strobe.
- xloc_start, output reg, 10: launch x, held stable.
- yloc_start, output reg, 10: launch y, held stable.
- move, output reg, 1: bullet step request.
- ready, output, 1: a press now would fire.
- shots_fired, output reg, 8: launch count, wraps 255→0.

Behaviour:
- Clock and reset: one clock (`clk`). Reset (`rst`) is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - shoot = 0, move = 0.
  - xloc_start = 0, yloc_start = 0, shots_fired = 0.
  - Debounce stable level = 0, debounce counter = 0.
  - Cooldown and move-divider counters = 0.
- Button conditioning:
  - fire_btn passes a 2-FF synchroniser.
  - The stable level updates after DEB_CYCLES consecutive clks at a new value.
  - A press event is a 0→1 transition of the stable level, one clk wide.
- Frame tick: `pixpulse & hcount==0 & vcount==V_TICK`. Exactly one clk per frame.
- FSM states IDLE, FIRE, FLIGHT, COOLDOWN:
  - IDLE: on `press & bullet_broken` go to FIRE. A press while `bullet_broken==0` is dropped, not queued.
  - FIRE (exactly 1 clk):
    - shoot = 1.
    - xloc_start ← ship_x.
    - yloc_start ← ship_y − Y_OFFSET, saturating at 0 when ship_y < Y_OFFSET.
    - shots_fired increments.
    - Next state FLIGHT.
    - Launch coords are latched in the FIRE clk and presented with shoot in the same registered cycle.
  - FLIGHT:
    - The first clk is a guard: bullet_broken is ignored, covering the engine's 1-clk latency to clear it.
    - Afterwards, `bullet_broken==1` → COOLDOWN, loading the counter with COOLDOWN_FRAMES.
    - If COOLDOWN_FRAMES==0, go directly to IDLE instead.
  - COOLDOWN: the counter decrements on each frame tick. When a tick makes it reach 0 → IDLE.
- ready = `(state==IDLE) & bullet_broken`, combinational.
- Move generation:
  - A divider counts frame ticks 0..MOVE_DIV−1.
  - On the tick where it wraps, move is set.
  - move is cleared on the next pixpulse after it was set, so the engine samples exactly one move per step.
  - Runs in all states; the engine ignores it while broken.
  - MOVE_DIV==0 is treated as 1.
- Simultaneous events:
  - A press in the same clk that FLIGHT→COOLDOWN occurs is dropped.
  - A frame tick during FIRE affects only the move divider.
- Reset mid-flight: returns to IDLE with all outputs cleared. The bullet engine is reset by the same `rst`.

Optional Feature:
- AUTOFIRE_EN defined: while the stable level is held at 1, IDLE with bullet_broken fires as if pressed. Holding the button gives one shot per (flight + cooldown) cycle.
- Not defined: only a 0→1 press event fires; a held button fires once.

Decomposition:
- Shared package `game_pkg`:
  - FSM state enum {IDLE, FIRE, FLIGHT, COOLDOWN}.
  - V_TICK = 10'd480, H_VISIBLE = 640, V_VISIBLE = 480.
- One sub-module: `btn_debounce` (synchroniser, stable counter, press-event output), parameterised by DEB_CYCLES.

Test Plan:
- DEB_CYCLES=4. Assert fire_btn for 3 clks then drop → no shoot. Hold for 6 clks with bullet_broken=1 → one shoot pulse. shots_fired = 1; xloc_start = ship_x = 320; yloc_start = 474 with ship_y = 480.
- ship_y=3, Y_OFFSET=6, press → yloc_start = 0 (saturation).
- Press while bullet_broken=0 → no shoot and ready=0. Press again after bullet_broken=1 and 8 frame ticks → shoot.
- COOLDOWN_FRAMES=2. Bullet dies, press on tick 1 → ignored. Press after tick 2 → fires. COOLDOWN_FRAMES=0 → fires in the next clk after death.
- MOVE_DIV=3 over 9 frames → exactly 3 move assertions, each covering exactly one pixpulse.
- Assert rst during FLIGHT → shoot=0, move=0, shots_fired=0 and state IDLE immediately (asynchronous). With AUTOFIRE_EN and a held button, firing resumes after debounce.
